// File: rtl/z80_vram_port.sv
// z80_vram_port: Z80 I/O-write to VRAM write queue bridge in the clk64 domain. Rev 1.0
// Optional build macro VRAM_AUTOINC_EN: value writes post-increment vram_addr.
`default_nettype none

module z80_vram_port #(
   parameter logic [7:0] ADDR_IO_ADDR_LOW  = 8'h40,
   parameter logic [7:0] ADDR_IO_ADDR_HIGH = ADDR_IO_ADDR_LOW + 8'd1,
   parameter logic [7:0] VALUE_IO_ADDR     = ADDR_IO_ADDR_HIGH + 8'd1,
   parameter int         FIFO_DEPTH        = 4
) (
   input  logic        clk64,
   input  logic        rst_n,
   input  logic        IORQ,
   input  logic        WR,
   input  logic [7:0]  A,
   input  logic [7:0]  D,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic [15:0] vram_addr,
   output logic [4:0]  fifo_level,
   output logic        overflow,
   input  logic        clr_overflow
);

   localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

   logic             iorq_s1, iorq_s2;
   logic             wr_s1, wr_s2;
   logic [7:0]       a_s1, a_s2;
   logic [7:0]       d_s1, d_s2;

   logic             strobe;
   logic             stb_q;
   logic [7:0]       port_q;
   logic [7:0]       data_q;

   logic             hit_lo, hit_hi, hit_val;
   logic             full, pop, push_ok, drop;

   logic [23:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [4:0]       level;
   logic [23:0]      head;

   // Strobe/control stages reset inactive so release never fakes a WR rising edge
   always_ff @(posedge clk64) begin
      if (!rst_n) begin
         iorq_s1 <= 1'b1;
         iorq_s2 <= 1'b1;
         wr_s1   <= 1'b1;
         wr_s2   <= 1'b1;
         a_s1    <= 8'h00;
         a_s2    <= 8'h00;
         d_s1    <= 8'h00;
         d_s2    <= 8'h00;
      end else begin
         iorq_s1 <= IORQ;
         iorq_s2 <= iorq_s1;
         wr_s1   <= WR;
         wr_s2   <= wr_s1;
         a_s1    <= A;
         a_s2    <= a_s1;
         d_s1    <= D;
         d_s2    <= d_s1;
      end
   end

   assign strobe = wr_s1 & ~wr_s2 & ~iorq_s2;

   // One capture stage so the register/FIFO update lands two edges after WR rise is seen
   always_ff @(posedge clk64) begin
      if (!rst_n) begin
         stb_q  <= 1'b0;
         port_q <= 8'h00;
         data_q <= 8'h00;
      end else begin
         stb_q  <= strobe;
         port_q <= a_s2;
         data_q <= d_s2;
      end
   end

   assign hit_lo  = stb_q && (port_q == ADDR_IO_ADDR_LOW);
   assign hit_hi  = stb_q && (port_q == ADDR_IO_ADDR_HIGH);
   assign hit_val = stb_q && (port_q == VALUE_IO_ADDR);

   always_ff @(posedge clk64) begin
      if (!rst_n) begin
         vram_addr <= 16'h0000;
      end else if (hit_lo) begin
         vram_addr[7:0] <= data_q;
      end else if (hit_hi) begin
         vram_addr[15:8] <= data_q;
`ifdef VRAM_AUTOINC_EN
      end else if (hit_val) begin
         vram_addr <= vram_addr + 16'd1;
`endif
      end
   end

   assign full     = (level == DEPTH_L);
   assign wr_valid = (level != 5'd0);
   assign pop      = wr_valid & wr_ready;
   // A pop frees the slot this same edge, so a full queue still accepts
   assign push_ok  = hit_val & (~full | pop);
   assign drop     = hit_val & full & ~pop;

   always_ff @(posedge clk64) begin
      if (push_ok) begin
         mem[wr_ptr] <= {vram_addr, data_q};
      end
   end

   always_ff @(posedge clk64) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= 5'd0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   level <= level + 5'd1;
            2'b01:   level <= level - 5'd1;
            default: level <= level;
         endcase
      end
   end

   // A new drop outranks a clear requested on the same edge
   always_ff @(posedge clk64) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

   assign head       = mem[rd_ptr];
   assign wr_addr    = wr_valid ? head[23:8] : 16'h0000;
   assign wr_data    = wr_valid ? head[7:0]  : 8'h00;
   assign fifo_level = level;

endmodule

`default_nettype wire

// File: tb/tb_z80_vram_port.sv
// tb_z80_vram_port: directed self-checking bench for z80_vram_port (default parameters).
`default_nettype none

module tb_z80_vram_port;

`ifdef VRAM_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic        clk64 = 1'b0;
   logic        rst_n;
   logic        IORQ, WR;
   logic [7:0]  A, D;
   logic        wr_valid, wr_ready;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic [15:0] vram_addr;
   logic [4:0]  fifo_level;
   logic        overflow, clr_overflow;

   int checks = 0;
   int errors = 0;

   z80_vram_port dut (
      .clk64        (clk64),
      .rst_n        (rst_n),
      .IORQ         (IORQ),
      .WR           (WR),
      .A            (A),
      .D            (D),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .vram_addr    (vram_addr),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   always #5 clk64 = ~clk64;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic z80_write(input logic [7:0] port, input logic [7:0] val);
      @(negedge clk64);
      A = port; D = val; IORQ = 1'b0; WR = 1'b0;
      repeat (3) @(negedge clk64);
      WR = 1'b1; IORQ = 1'b1;
      repeat (4) @(negedge clk64);
   endtask

   // Value write with wr_ready and/or clr_overflow asserted only on the push edge
   task automatic z80_value_at_push(input logic [7:0] val, input bit use_pop, input bit use_clr);
      @(negedge clk64);
      A = 8'h42; D = val; IORQ = 1'b0; WR = 1'b0;
      repeat (3) @(negedge clk64);
      WR = 1'b1; IORQ = 1'b1;
      @(posedge clk64);
      @(posedge clk64);
      @(negedge clk64);
      wr_ready = use_pop; clr_overflow = use_clr;
      @(posedge clk64);
      #1;
      wr_ready = 1'b0; clr_overflow = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [15:0] ea, input logic [7:0] ed);
      @(negedge clk64);
      check_value({tag, "_valid"}, 32'(wr_valid), 32'd1);
      check_value({tag, "_addr"},  32'(wr_addr),  32'(ea));
      check_value({tag, "_data"},  32'(wr_data),  32'(ed));
      wr_ready = 1'b1;
      @(posedge clk64);
      #1;
      wr_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; IORQ = 1'b1; WR = 1'b1; A = 8'h00; D = 8'h00;
      wr_ready = 1'b0; clr_overflow = 1'b0;
      repeat (3) @(posedge clk64);
      #1;
      check_value("rst_valid",    32'(wr_valid),   32'd0);
      check_value("rst_level",    32'(fifo_level), 32'd0);
      check_value("rst_overflow", 32'(overflow),   32'd0);
      check_value("rst_vaddr",    32'(vram_addr),  32'd0);
      check_value("rst_waddr",    32'(wr_addr),    32'd0);
      check_value("rst_wdata",    32'(wr_data),    32'd0);
      @(negedge clk64);
      rst_n = 1'b1;

      // Basic pointer load and value write with exact latency
      wr_ready = 1'b1;
      z80_write(8'h41, 8'h12);
      z80_write(8'h40, 8'h34);
      check_value("ptr_load", 32'(vram_addr), 32'h1234);
      @(negedge clk64);
      A = 8'h42; D = 8'hAB; IORQ = 1'b0; WR = 1'b0;
      repeat (3) @(negedge clk64);
      WR = 1'b1; IORQ = 1'b1;
      @(posedge clk64);
      @(posedge clk64);
      #1;
      check_value("lat_n1_valid", 32'(wr_valid), 32'd0);
      @(posedge clk64);
      #1;
      check_value("lat_n2_valid", 32'(wr_valid), 32'd1);
      check_value("lat_n2_addr",  32'(wr_addr),  32'h1234);
      check_value("lat_n2_data",  32'(wr_data),  32'hAB);
      @(posedge clk64);
      #1;
      check_value("lat_n3_valid", 32'(wr_valid),   32'd0);
      check_value("lat_n3_level", 32'(fifo_level), 32'd0);
      check_value("val_ptr", 32'(vram_addr), AUTOINC ? 32'h1235 : 32'h1234);

      // Other port and read cycle ignored
      wr_ready = 1'b0;
      z80_write(8'h43, 8'h55);
      @(negedge clk64);
      A = 8'h42; D = 8'h66; IORQ = 1'b0;
      repeat (4) @(negedge clk64);
      IORQ = 1'b1;
      repeat (3) @(negedge clk64);
      check_value("ign_level", 32'(fifo_level), 32'd0);
      check_value("ign_valid", 32'(wr_valid),   32'd0);
      check_value("ign_vaddr", 32'(vram_addr),  AUTOINC ? 32'h1235 : 32'h1234);

      // Pointer wrap behaviour
      z80_write(8'h41, 8'hFF);
      z80_write(8'h40, 8'hFE);
      z80_write(8'h42, 8'h01);
      z80_write(8'h42, 8'h02);
      z80_write(8'h42, 8'h03);
      check_value("wrap_level", 32'(fifo_level), 32'd3);
      check_value("wrap_vaddr", 32'(vram_addr), AUTOINC ? 32'h0001 : 32'hFFFE);
      pop_check("wrap0", 16'hFFFE, 8'h01);
      pop_check("wrap1", AUTOINC ? 16'hFFFF : 16'hFFFE, 8'h02);
      pop_check("wrap2", AUTOINC ? 16'h0000 : 16'hFFFE, 8'h03);
      check_value("wrap_empty", 32'(wr_valid), 32'd0);

      // Overflow: six writes into depth 4
      z80_write(8'h41, 8'h20);
      z80_write(8'h40, 8'h00);
      for (int i = 0; i < 6; i++) z80_write(8'h42, 8'(8'h10 + i));
      check_value("ovf_level", 32'(fifo_level), 32'd4);
      check_value("ovf_flag",  32'(overflow),   32'd1);
      check_value("ovf_vaddr", 32'(vram_addr), AUTOINC ? 32'h2006 : 32'h2000);
      for (int i = 0; i < 4; i++)
         pop_check("ovf_drain", AUTOINC ? 16'(16'h2000 + i) : 16'h2000, 8'(8'h10 + i));
      check_value("ovf_after_level", 32'(fifo_level), 32'd0);
      check_value("ovf_sticky",      32'(overflow),   32'd1);
      @(negedge clk64);
      clr_overflow = 1'b1;
      @(posedge clk64);
      #1;
      clr_overflow = 1'b0;
      check_value("ovf_clr", 32'(overflow), 32'd0);

      // Full FIFO: push coinciding with pop
      z80_write(8'h41, 8'h30);
      z80_write(8'h40, 8'h00);
      for (int i = 0; i < 4; i++) z80_write(8'h42, 8'(8'h20 + i));
      z80_value_at_push(8'h24, 1'b1, 1'b0);
      check_value("pp_level", 32'(fifo_level), 32'd4);
      check_value("pp_ovf",   32'(overflow),   32'd0);
      for (int i = 1; i < 5; i++)
         pop_check("pp_drain", AUTOINC ? 16'(16'h3000 + i) : 16'h3000, 8'(8'h20 + i));

      // Drop beats a same-edge clear, then reset mid-contents
      for (int i = 0; i < 5; i++) z80_write(8'h42, 8'(8'h30 + i));
      check_value("drop_ovf", 32'(overflow), 32'd1);
      z80_value_at_push(8'h35, 1'b0, 1'b1);
      check_value("drop_wins", 32'(overflow), 32'd1);
      pop_check("drop_head", AUTOINC ? 16'h3005 : 16'h3000, 8'h30);
      check_value("pre_rst_level", 32'(fifo_level), 32'd3);
      @(negedge clk64);
      rst_n = 1'b0;
      @(posedge clk64);
      #1;
      check_value("rst2_valid", 32'(wr_valid),   32'd0);
      check_value("rst2_level", 32'(fifo_level), 32'd0);
      check_value("rst2_ovf",   32'(overflow),   32'd0);
      check_value("rst2_vaddr", 32'(vram_addr),  32'd0);
      @(negedge clk64);
      rst_n = 1'b1;
      z80_write(8'h40, 8'h77);
      check_value("post_rst_ptr", 32'(vram_addr), 32'h0077);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/z80_vram_port.md
Z80_VRAM_PORT -- requirements
Module: z80_vram_port

Interface
REQ-001 SHALL provide parameter ADDR_IO_ADDR_LOW, default 8'h40, the I/O port that loads vram_addr[7:0].
REQ-002 SHALL provide parameter ADDR_IO_ADDR_HIGH, default ADDR_IO_ADDR_LOW+1, the I/O port that loads vram_addr[15:8].
REQ-003 SHALL provide parameter VALUE_IO_ADDR, default ADDR_IO_ADDR_HIGH+1, the I/O port that queues a VRAM byte write.
REQ-004 SHALL provide parameter FIFO_DEPTH, default 4 (power of two, 2..16), the write-queue entry count.
REQ-005 clk64  in  1  sole clock, the SDRAM-domain clock; one clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 IORQ  in  1  Z80 /IORQ, asynchronous, active-low.
REQ-008 WR  in  1  Z80 /WR, asynchronous, active-low.
REQ-009 A  in  8  Z80 address low byte, asynchronous.
REQ-010 D  in  8  Z80 data bus, asynchronous.
REQ-011 wr_valid  out  1  queue head valid toward SDRAM write sequencer.
REQ-012 wr_ready  in  1  sequencer accepts head this cycle.
REQ-013 wr_addr  out  16  head entry VRAM address.
REQ-014 wr_data  out  8  head entry byte.
REQ-015 vram_addr  out  16  current write pointer.
REQ-016 fifo_level  out  5  occupied entries, 0..FIFO_DEPTH.
REQ-017 overflow  out  1  sticky, a value write was dropped.
REQ-018 clr_overflow  in  1  synchronous clear of overflow.

Function
REQ-019 IORQ, WR, A, D SHALL each pass through a two-flop synchronizer (s1, s2) in clk64.
REQ-020 I/O write strobe SHALL fire in the cycle where WR_s1=1, WR_s2=0 and IORQ_s2=0; port and data are taken from A_s2, D_s2.
REQ-021 Strobe latency: WR high first sampled at edge N -> register updates and FIFO push at edge N+2; wr_valid visible after N+2.
REQ-022 Strobe on ADDR_IO_ADDR_LOW SHALL load vram_addr[7:0]; on ADDR_IO_ADDR_HIGH SHALL load vram_addr[15:8]; other bits unchanged.
REQ-023 Strobe on VALUE_IO_ADDR SHALL push {vram_addr, D_s2} into the FIFO.
REQ-024 Strobes to any other port SHALL be ignored.
REQ-025 FIFO SHALL be first-word-fall-through: wr_addr/wr_data reflect the oldest entry whenever wr_valid=1.
REQ-026 Pop occurs on edge where wr_valid & wr_ready; wr_ready while empty has no effect.
REQ-027 Push and pop in same cycle SHALL both take effect, level unchanged, including when full.
REQ-028 Push when full without pop: entry dropped, overflow set to 1, level stays FIFO_DEPTH.
REQ-029 Queued entries SHALL keep their captured address; later pointer writes affect only later pushes.
REQ-030 clr_overflow SHALL clear overflow on the next edge; a simultaneous new drop SHALL win (overflow stays 1).
REQ-031 fifo_level SHALL equal pushes minus pops since reset, never exceeding FIFO_DEPTH.

Reset
REQ-032 rst_n=0 at an edge SHALL set: vram_addr=0, FIFO empty, fifo_level=0, wr_valid=0, overflow=0, wr_addr=0, wr_data=0.
REQ-033 Synchronizers SHALL reset IORQ and WR stages to 1, A and D stages to 0, so no strobe fires in the first two cycles after release.
REQ-034 Reset mid-Z80-cycle SHALL discard any pending strobe; a write whose WR rising edge completes after release SHALL be processed normally.

Configuration
REQ-035 Macro VRAM_AUTOINC_EN defined: each VALUE_IO_ADDR strobe SHALL increment vram_addr by 1 (16'hFFFF wraps to 16'h0000) in the same edge as the push, including dropped pushes.
REQ-036 Macro absent: vram_addr SHALL change only via port writes; value writes leave it unchanged.

Verification
REQ-037 Write 0x12 to 0x41, 0x34 to 0x40, 0xAB to 0x42, wr_ready=1 -> one wr_valid pulse, wr_addr=0x1234, wr_data=0xAB, exactly N+2 edges after WR rise.
REQ-038 With VRAM_AUTOINC_EN, pointer 0xFFFE, three value writes 0x01,0x02,0x03 -> entries at 0xFFFE, 0xFFFF, 0x0000; vram_addr ends 0x0001; without macro all at 0xFFFE.
REQ-039 wr_ready=0, six value writes (depth 4) -> fifo_level=4, overflow=1, then wr_ready=1 drains first four bytes in order.
REQ-040 Full FIFO, value write coinciding with pop -> level stays 4, no overflow, new byte last out.
REQ-041 Write to port 0x43 and a read cycle (WR high, IORQ low) -> no push, vram_addr unchanged.
REQ-042 rst_n=0 while FIFO holds 3 entries and overflow=1 -> next cycle wr_valid=0, fifo_level=0, overflow=0, vram_addr=0.
